reg_dump_reader: RTL

Debug read-out engine for the CPU register file. On a start pulse it walks a configurable, wrapping address range over one register-file read port and streams each `{index, value}` pair out on a valid/ready handshake, with a last-word flag and a completion pulse. It sits beside the register file and shares a read port with the decode stage via an external mux. It lets the testbench or a debug host dump architectural state without `$display` calls inside the register file.

---
 rtl/reg_dump_reader_if.sv | 30 +++
 rtl/reg_dump_reader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/reg_dump_reader_if.sv
// Output stream of the register dump engine: one {index, value} word per
// valid/ready handshake, with a flag marking the final word of the range.
interface reg_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    // Producer side: the dump engine presents words and watches ready.
    modport master (
        output out_valid,
        output out_index,
        output out_data,
        output out_last,
        input  out_ready
    );

    // Consumer side: the debug host or bench accepts words.
    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks a wrapping register range over one
// register-file read port and streams each {index, value} pair out on a
// valid/ready handshake, pulsing done after the final word is accepted.
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    reg_dump_reader_if.master dump,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic              capture_s;
    logic              advance_s;
    logic              finish_s;
    logic [ADDR_W-1:0] cur_r;
    logic [ADDR_W-1:0] last_r;
    logic [ADDR_W-1:0] cur_inc_s;
    logic              busy_r;
    logic              done_r;

    // cur_r is parked at 0 whenever the engine is idle, so it can drive the
    // read port directly and the port address stays a registered value.
    assign rf_addr   = cur_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cur_inc_s = (cur_r == ADDR_W'(NUM_REGS - 1)) ? {ADDR_W{1'b0}}
                                                        : cur_r + ADDR_W'(1);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and one-cycle control strobes for the datapath.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        advance_s    = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // A start coinciding with the done pulse is dropped so a
                // host holding start high cannot chain dumps back to back.
                if (start && !done_r) begin
                    accept_s     = 1'b1;
                    next_state_s = READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ: begin
                capture_s    = 1'b1;
                next_state_s = HOLD;
            end
            HOLD: begin
                if (dump.out_valid && dump.out_ready) begin
                    if (dump.out_last) begin
                        finish_s     = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        advance_s    = 1'b1;
                        next_state_s = READ;
                    end
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Range pointers, captured output word and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_r          <= {ADDR_W{1'b0}};
            last_r         <= {ADDR_W{1'b0}};
            dump.out_valid <= 1'b0;
            dump.out_index <= {ADDR_W{1'b0}};
            dump.out_data  <= {DATA_W{1'b0}};
            dump.out_last  <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            done_r <= finish_s;
            if (accept_s) begin
                cur_r  <= start_addr;
                last_r <= end_addr;
                busy_r <= 1'b1;
            end
            // The value is sampled once here and then frozen in HOLD, so
            // later register-file writes never disturb a presented word.
            if (capture_s) begin
                dump.out_data  <= rf_data;
                dump.out_index <= cur_r;
                dump.out_last  <= (cur_r == last_r);
                dump.out_valid <= 1'b1;
            end
            if (advance_s) begin
                dump.out_valid <= 1'b0;
                cur_r          <= cur_inc_s;
            end
            if (finish_s) begin
                dump.out_valid <= 1'b0;
                cur_r          <= {ADDR_W{1'b0}};
                busy_r         <= 1'b0;
            end
        end
    end

endmodule
